uart_loader: RTL and testbench
==============================

# uart_loader

Boot-time program loader upstream of the CPU/memory pair in the iCE top level. It receives a program image over a UART RX pin, assembles bytes into 32-bit words, and writes them sequentially into instruction/data memory through the same write port the CPU uses. While loading, it holds the CPU in reset; it releases the CPU once the last word is committed.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 104: `clk` cycles per UART bit (12 MHz / 115200). Minimum 4.
- `ADDR_WIDTH`, default 8: memory word-address width.

Ports:
- `clk`, input, 1: system clock (the undivided `CLK` net).
- `reset`, input, 1: synchronous, active-high.
- `rx`, input, 1: UART receive line, asynchronous, idle high, 8N1, LSB first.
- `write_address`, output, ADDR_WIDTH: memory word address.
- `write_data`, output, 32: word to write.
- `write_enable`, output, 1: one-cycle write strobe.
- `cpu_hold`, output, 1: high holds the CPU in reset.
- `loading`, output, 1: high while the image is incomplete.
- `frame_error`, output, 1: sticky; set on any stop-bit error and cleared only by `reset`.

## Operation

- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. All sampling uses the synchronized value.
- RX FSM:
  - RX_IDLE: on a low sample, clear the bit counter and go to RX_START.
  - RX_START: wait CLKS_PER_BIT/2 cycles, then re-sample. If low, go to RX_DATA. If high, treat it as a glitch and return to RX_IDLE.
  - RX_DATA: sample every CLKS_PER_BIT cycles. Shift in 8 bits, LSB first, then go to RX_STOP.
  - RX_STOP: after CLKS_PER_BIT cycles, sample. If high, pulse internal `byte_valid` for one cycle. If low, set `frame_error` and discard the byte. Either way, return to RX_IDLE.
- Loader FSM:
  - L_COUNT: the first valid byte is word count N; 0 means 256 (9-bit internal count). Go to L_DATA.
  - L_DATA: assemble bytes little-endian (byte 0 goes to bits [7:0]) using a 2-bit byte index.
    - On the 4th byte, register the word and pulse `write_enable`.
    - Increment the address after the write.
    - When words written equals N, go to L_DONE.
  - L_DONE: ignore all further bytes, assert no writes, and deassert `cpu_hold`.
- Discarded (framing-error) bytes do not advance the byte index. Assembly resumes with the next good byte.
- Address wraps modulo 2^ADDR_WIDTH. With the default width and N=256, the final address is 0xFF and no wrap occurs.

## Timing

- Reset values:
  - `write_address`=0, `write_data`=0, `write_enable`=0.
  - `cpu_hold`=1, `loading`=1, `frame_error`=0.
  - RX FSM in RX_IDLE, loader FSM in L_COUNT, byte index 0, word count 0.
- Input latency: 2 cycles through the synchronizer.
- Bit sampling: data bit k is sampled (CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT) cycles after the start edge, as seen post-synchronizer.
- `byte_valid` rises in the cycle the stop bit is sampled.
- `write_enable` asserts exactly one cycle after `byte_valid` of the 4th byte. It is high for exactly one cycle.
- `write_address` and `write_data` are stable during the `write_enable` cycle. They hold their values until the next write.
- `cpu_hold` and `loading` fall together one cycle after the final `write_enable` pulse. They stay low until `reset`.
- A new start bit may be detected the cycle after the RX_STOP sample, so back-to-back bytes with a 1-bit stop are supported.
- `reset` has priority over everything, including mid-byte and mid-word. All partial state is discarded.

## Test plan

Run all scenarios with CLKS_PER_BIT=4.

- **Reset values:** hold `reset` for 3 cycles with `rx`=1 → `cpu_hold`=1, `loading`=1, `write_enable`=0, `frame_error`=0, `write_address`=0.
- **Two-word load:** send bytes 02, 44 33 22 11, EF BE AD DE →
  - `write_enable` pulses at address 0 with data 0x11223344;
  - it pulses at address 1 with data 0xDEADBEEF;
  - `cpu_hold` falls 1 cycle later;
  - a further byte AA produces no write.
- **Count zero:** send count 00, then 1024 bytes → exactly 256 write pulses; the last is at address 0xFF; `cpu_hold` falls after it.
- **Framing error:** count 01, then byte 44 with stop bit driven low → `frame_error`=1 and no byte is counted. Then send 44 33 22 11 → a single write of 0x11223344 at address 0; `frame_error` remains 1.
- **Start glitch:** drive `rx` low for 1 cycle while idle → no byte accepted and FSM back in RX_IDLE. A following valid count byte is accepted normally.
- **Reset mid-load:** count 03, one full word, then 2 bytes, then `reset` → address returns to 0, `cpu_hold`=1, partial bytes are lost. A fresh load of count 01 with 01 00 00 00 writes 0x00000001 at address 0.

Source files
------------

// File: rtl/uart_loader.sv
// Boot loader: receives an 8N1 UART image (count byte, then little-endian words),
// writes the words sequentially into memory and holds the CPU in reset until done.
module uart_loader #(
   parameter int CLKS_PER_BIT = 104,
   parameter int ADDR_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx,
   output logic [ADDR_WIDTH-1:0] write_address,
   output logic [31:0]           write_data,
   output logic                  write_enable,
   output logic                  cpu_hold,
   output logic                  loading,
   output logic                  frame_error
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {L_COUNT, L_DATA, L_DONE} ld_state_t;

   // Handshake: byte_valid is a single-cycle strobe; rx_byte is valid only while it is high.
   // The loader has no back-pressure and must accept every strobe.
   logic             rx_meta, rx_sync;
   rx_state_t        rx_state, rx_next;
   logic [CNT_W-1:0] clk_cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       rx_byte;
   logic             half_tick, bit_tick;
   logic             byte_valid, stop_bad;

   ld_state_t        ld_state, ld_next;
   logic [1:0]       byte_idx;
   logic [23:0]      word_buf;
   logic [8:0]       word_count;
   logic [8:0]       words_written;
   logic [ADDR_WIDTH-1:0] next_address;
   logic             last_byte;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   assign half_tick = (clk_cnt == HALF_M1);
   assign bit_tick  = (clk_cnt == FULL_M1);

   always_comb begin
      rx_next    = rx_state;
      byte_valid = 1'b0;
      stop_bad   = 1'b0;
      case (rx_state)
         RX_IDLE:  if (!rx_sync) rx_next = RX_START;
         RX_START: if (half_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (bit_tick && bit_cnt == 3'd7) rx_next = RX_STOP;
         RX_STOP: begin
            if (bit_tick) begin
               rx_next    = RX_IDLE;
               byte_valid = rx_sync;
               stop_bad   = !rx_sync;
            end
         end
         default:  rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state    <= RX_IDLE;
         clk_cnt     <= '0;
         bit_cnt     <= 3'd0;
         rx_byte     <= 8'd0;
         frame_error <= 1'b0;
      end else begin
         rx_state <= rx_next;
         case (rx_state)
            RX_IDLE: begin
               clk_cnt <= '0;
               bit_cnt <= 3'd0;
            end
            RX_START: clk_cnt <= half_tick ? '0 : clk_cnt + CNT_W'(1);
            RX_DATA: begin
               if (bit_tick) begin
                  clk_cnt <= '0;
                  rx_byte <= {rx_sync, rx_byte[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
               end else begin
                  clk_cnt <= clk_cnt + CNT_W'(1);
               end
            end
            RX_STOP:  clk_cnt <= bit_tick ? '0 : clk_cnt + CNT_W'(1);
            default:  clk_cnt <= '0;
         endcase
         if (stop_bad) frame_error <= 1'b1;
      end
   end

   assign last_byte = byte_valid && (ld_state == L_DATA) && (byte_idx == 2'd3);

   always_comb begin
      ld_next = ld_state;
      case (ld_state)
         L_COUNT: if (byte_valid) ld_next = L_DATA;
         L_DATA:  if (last_byte && (words_written + 9'd1 == word_count)) ld_next = L_DONE;
         L_DONE:  ld_next = L_DONE;
         default: ld_next = L_COUNT;
      endcase
   end

   // write_address shows the address of the most recent write; next_address runs one ahead,
   // so a full 256-word image leaves 0xFF visible rather than the wrapped 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         ld_state      <= L_COUNT;
         byte_idx      <= 2'd0;
         word_buf      <= 24'd0;
         word_count    <= 9'd0;
         words_written <= 9'd0;
         next_address  <= '0;
         write_address <= '0;
         write_data    <= 32'd0;
         write_enable  <= 1'b0;
         cpu_hold      <= 1'b1;
         loading       <= 1'b1;
      end else begin
         ld_state     <= ld_next;
         write_enable <= last_byte;
         cpu_hold     <= (ld_state != L_DONE);
         loading      <= (ld_state != L_DONE);
         if (byte_valid && ld_state == L_COUNT) begin
            word_count <= (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
         end
         if (byte_valid && ld_state == L_DATA) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
               2'd0: word_buf[7:0]   <= rx_byte;
               2'd1: word_buf[15:8]  <= rx_byte;
               2'd2: word_buf[23:16] <= rx_byte;
               default: begin
                  write_data    <= {rx_byte, word_buf};
                  write_address <= next_address;
                  next_address  <= next_address + ADDR_WIDTH'(1);
                  words_written <= words_written + 9'd1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader at CLKS_PER_BIT=4: single-word load table plus
// hand-written multi-byte sequences for count-zero, framing error, glitch and reset.
module tb_uart_loader;

   localparam int CPB = 4;
   localparam int AW  = 8;
   localparam int W   = AW + 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          rx = 1'b1;
   logic [AW-1:0] write_address;
   logic [31:0]   write_data;
   logic          write_enable;
   logic          cpu_hold;
   logic          loading;
   logic          frame_error;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];
   int  we_run = 0;
   int  max_we_run = 0;
   int  last_we_cyc = 0;
   int  hold_fall_cyc = 0;
   logic prev_hold = 1'b1;

   uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .rx(rx),
      .write_address(write_address), .write_data(write_data),
      .write_enable(write_enable), .cpu_hold(cpu_hold),
      .loading(loading), .frame_error(frame_error)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // write monitor: records every strobe, pulse width and cpu_hold fall time
   always @(negedge clk) begin
      if (reset) begin
         got_q.delete();
         we_run        <= 0;
         max_we_run    <= 0;
         last_we_cyc   <= 0;
         hold_fall_cyc <= 0;
         prev_hold     <= 1'b1;
      end else begin
         if (write_enable) begin
            got_q.push_back({write_address, write_data});
            last_we_cyc <= cyc;
            we_run      <= we_run + 1;
            if (we_run + 1 > max_we_run) max_we_run <= we_run + 1;
         end else begin
            we_run <= 0;
         end
         if (prev_hold && !cpu_hold) hold_fall_cyc <= cyc;
         prev_hold <= cpu_hold;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b1;
      rx = 1'b1;
      repeat (n) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_bit(input logic v);
      rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop);
      if (!stop) begin
         rx = 1'b1;
         repeat (2 * CPB) @(negedge clk);
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[7:0], 1'b1);
      send_byte(w[15:8], 1'b1);
      send_byte(w[23:16], 1'b1);
      send_byte(w[31:24], 1'b1);
   endtask

   task automatic settle();
      rx = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // scoreboard: compare recorded writes with the expected queue, then drain it
   task automatic score(input string name);
      check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check({name, "_write"}, 64'(got_q[i]), 64'(exp_q[i]));
      exp_q.delete();
   endtask

   typedef struct {
      logic [31:0]   word;
      logic [AW-1:0] exp_addr;
      logic [31:0]   exp_data;
      logic          exp_hold;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{32'h11223344, 8'h00, 32'h11223344, 1'b0};
      vecs[1] = '{32'h00000001, 8'h00, 32'h00000001, 1'b0};
      vecs[2] = '{32'hFFFFFFFF, 8'h00, 32'hFFFFFFFF, 1'b0};
      vecs[3] = '{32'h80000001, 8'h00, 32'h80000001, 1'b0};
      vecs[4] = '{32'hA55A0FF0, 8'h00, 32'hA55A0FF0, 1'b0};

      // reset values
      reset = 1'b1;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
      check("rst_loading", 64'(loading), 64'd1);
      check("rst_we", 64'(write_enable), 64'd0);
      check("rst_fe", 64'(frame_error), 64'd0);
      check("rst_addr", 64'(write_address), 64'd0);
      check("rst_data", 64'(write_data), 64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // table: single-word loads
      for (int v = 0; v < 5; v++) begin
         do_reset(2);
         send_byte(8'h01, 1'b1);
         send_word(vecs[v].word);
         settle();
         exp_q.push_back({vecs[v].exp_addr, vecs[v].exp_data});
         score("vec");
         check("vec_hold", 64'(cpu_hold), 64'(vecs[v].exp_hold));
         check("vec_loading", 64'(loading), 64'(vecs[v].exp_hold));
      end

      // two-word load
      do_reset(2);
      send_byte(8'h02, 1'b1);
      send_word(32'h11223344);
      settle();
      check("two_mid_hold", 64'(cpu_hold), 64'd1);
      send_word(32'hDEADBEEF);
      settle();
      exp_q.push_back({8'h00, 32'h11223344});
      exp_q.push_back({8'h01, 32'hDEADBEEF});
      score("two");
      check("two_pulse_width", 64'(max_we_run), 64'd1);
      check("two_hold_lag", 64'(hold_fall_cyc - last_we_cyc), 64'd1);
      check("two_hold", 64'(cpu_hold), 64'd0);
      check("two_loading", 64'(loading), 64'd0);
      send_byte(8'hAA, 1'b1);
      settle();
      check("two_extra_count", 64'(got_q.size()), 64'd2);
      check("two_addr_hold", 64'(write_address), 64'h01);
      check("two_data_hold", 64'(write_data), 64'hDEADBEEF);

      // count zero means 256 words
      do_reset(2);
      send_byte(8'h00, 1'b1);
      for (int i = 0; i < 256; i++) begin
         logic [31:0] w;
         w = {8'(i), 8'hA5, 8'(255 - i), 8'h3C};
         send_word(w);
         exp_q.push_back({8'(i), w});
      end
      settle();
      score("n256");
      check("n256_pulse_width", 64'(max_we_run), 64'd1);
      check("n256_final_addr", 64'(write_address), 64'hFF);
      check("n256_hold", 64'(cpu_hold), 64'd0);
      check("n256_hold_lag", 64'(hold_fall_cyc - last_we_cyc), 64'd1);

      // framing error discards the byte and is sticky
      do_reset(2);
      send_byte(8'h01, 1'b1);
      send_byte(8'h44, 1'b0);
      settle();
      check("fe_set", 64'(frame_error), 64'd1);
      check("fe_no_write", 64'(got_q.size()), 64'd0);
      send_word(32'h11223344);
      settle();
      exp_q.push_back({8'h00, 32'h11223344});
      score("fe");
      check("fe_sticky", 64'(frame_error), 64'd1);
      check("fe_hold", 64'(cpu_hold), 64'd0);

      // one-cycle start glitch is rejected
      do_reset(2);
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (4 * CPB) @(negedge clk);
      check("gl_no_write", 64'(got_q.size()), 64'd0);
      check("gl_hold", 64'(cpu_hold), 64'd1);
      check("gl_fe", 64'(frame_error), 64'd0);
      send_byte(8'h01, 1'b1);
      send_word(32'h00000001);
      settle();
      exp_q.push_back({8'h00, 32'h00000001});
      score("gl");
      check("gl_done", 64'(cpu_hold), 64'd0);

      // reset in the middle of a load
      do_reset(2);
      send_byte(8'h03, 1'b1);
      send_word(32'h11223344);
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      settle();
      check("mid_pre_count", 64'(got_q.size()), 64'd1);
      check("mid_pre_addr", 64'(write_address), 64'h00);
      do_reset(2);
      check("mid_addr", 64'(write_address), 64'd0);
      check("mid_hold", 64'(cpu_hold), 64'd1);
      check("mid_loading", 64'(loading), 64'd1);
      check("mid_data", 64'(write_data), 64'd0);
      send_byte(8'h01, 1'b1);
      send_word(32'h00000001);
      settle();
      exp_q.push_back({8'h00, 32'h00000001});
      score("mid");
      check("mid_done", 64'(cpu_hold), 64'd0);

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
